// File: rtl/rr_process_scheduler.sv
// rr_process_scheduler: round-robin process table, quantum counter and context-switch handshake to the CPU PC mux.
// Latency: create_ok/create_full one cycle after create_valid; switch_req two cycles after a RUN event (SELECT, DISPATCH).
// Backpressure: switch_req/switch_pid/switch_pc held stable until switch_ack; SCHED_STATS_EN adds switch/preempt counters.
module rr_process_scheduler #(
    parameter int NUM_PROC = 4,
    parameter int QUANTUM  = 8,
    parameter int PC_W     = 32,
    localparam int PID_W   = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             create_valid,
    input  logic [PC_W-1:0]  create_pc,
    output logic             create_ok,
    output logic             create_full,
    output logic [PID_W-1:0] create_pid,
    input  logic             instr_retire,
    input  logic             io_block,
    input  logic             io_done,
    input  logic [PID_W-1:0] io_pid,
    input  logic             proc_end,
    input  logic [PC_W-1:0]  save_pc,
    output logic             switch_req,
    output logic [PID_W-1:0] switch_pid,
    output logic [PC_W-1:0]  switch_pc,
    input  logic             switch_ack,
    output logic [PID_W-1:0] current_pid,
    output logic             running,
    output logic             idle
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]      switch_count,
    output logic [15:0]      preempt_count
`endif
);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_BLOCKED, SLOT_RUNNING} slot_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_DISPATCH, ST_RUN} state_e;

    localparam int              CNT_W    = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    slot_e            slot_q [NUM_PROC];
    slot_e            slot_d [NUM_PROC];
    logic [PC_W-1:0]  pc_q   [NUM_PROC];
    logic [PC_W-1:0]  pc_d   [NUM_PROC];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PID_W-1:0] cur_q, cur_d;
    logic [PID_W-1:0] sw_pid_q, sw_pid_d;
    logic [PC_W-1:0]  sw_pc_q, sw_pc_d;
    logic             crt_ok_q, crt_ok_d;
    logic             crt_full_q, crt_full_d;
    logic [PID_W-1:0] crt_pid_q, crt_pid_d;

    logic             any_ready;
    logic             free_found;
    logic [PID_W-1:0] free_pid;
    logic             sel_found;
    logic [PID_W-1:0] sel_pid;
    logic             expire;
    logic             ack_fire;

    // PID at distance k+1 from base, wrapping modulo NUM_PROC (works for non-power-of-two tables)
    function automatic logic [PID_W-1:0] wrap_pid(input logic [PID_W-1:0] base, input int k);
        return PID_W'((int'(base) + 1 + k) % NUM_PROC);
    endfunction

    // Lowest-index FREE slot for creation, plus "anything runnable" for leaving IDLE
    always_comb begin
        free_found = 1'b0;
        free_pid   = '0;
        any_ready  = 1'b0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_pid   = PID_W'(i);
            end
            if (slot_q[i] == SLOT_READY) begin
                any_ready = 1'b1;
            end
        end
    end

    // Round-robin pick: start after current_pid, current_pid itself is considered last
    always_comb begin
        sel_found = 1'b0;
        sel_pid   = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            if (!sel_found && slot_q[wrap_pid(cur_q, k)] == SLOT_READY) begin
                sel_found = 1'b1;
                sel_pid   = wrap_pid(cur_q, k);
            end
        end
    end

    // Next-state: FSM, slot table updates from create / io_done / RUN events, quantum counter
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        sw_pid_d   = sw_pid_q;
        sw_pc_d    = sw_pc_q;
        expire     = 1'b0;
        ack_fire   = 1'b0;
        crt_ok_d   = create_valid && free_found;
        crt_full_d = create_valid && !free_found;
        crt_pid_d  = (create_valid && free_found) ? free_pid : '0;

        // Only a slot already BLOCKED can be woken; anything else is a stray completion
        if (io_done && (int'(io_pid) < NUM_PROC) && slot_q[io_pid] == SLOT_BLOCKED) begin
            slot_d[io_pid] = SLOT_READY;
        end

        // Uses registered slot state, so a slot freed this cycle is not reused until next cycle
        if (create_valid && free_found) begin
            slot_d[free_pid] = SLOT_READY;
            pc_d[free_pid]   = create_pc;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_ready) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    sw_pid_d = sel_pid;
                    sw_pc_d  = pc_q[sel_pid];
                    state_d  = ST_DISPATCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (switch_ack) begin
                    ack_fire         = 1'b1;
                    slot_d[sw_pid_q] = SLOT_RUNNING;
                    cur_d            = sw_pid_q;
                    cnt_d            = CNT_LOAD;
                    state_d          = ST_RUN;
                end
            end
            ST_RUN: begin
                if (proc_end) begin
                    slot_d[cur_q] = SLOT_FREE;
                    state_d       = ST_SELECT;
                end else if (io_block) begin
                    slot_d[cur_q] = SLOT_BLOCKED;
                    pc_d[cur_q]   = save_pc;
                    state_d       = ST_SELECT;
                end else if (instr_retire) begin
                    if (cnt_q == CNT_ONE) begin
                        expire        = 1'b1;
                        slot_d[cur_q] = SLOT_READY;
                        pc_d[cur_q]   = save_pc;
                        state_d       = ST_SELECT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset returns every slot to FREE and the FSM to IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            sw_pid_q   <= '0;
            sw_pc_q    <= '0;
            crt_ok_q   <= 1'b0;
            crt_full_q <= 1'b0;
            crt_pid_q  <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                slot_q[i] <= SLOT_FREE;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            sw_pid_q   <= sw_pid_d;
            sw_pc_q    <= sw_pc_d;
            crt_ok_q   <= crt_ok_d;
            crt_full_q <= crt_full_d;
            crt_pid_q  <= crt_pid_d;
            slot_q     <= slot_d;
            pc_q       <= pc_d;
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] switch_count_q;
    logic [15:0] preempt_count_q;

    // Saturating counts of accepted dispatches and quantum preemptions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            switch_count_q  <= '0;
            preempt_count_q <= '0;
        end else begin
            if (ack_fire && switch_count_q != 16'hFFFF) begin
                switch_count_q <= switch_count_q + 16'd1;
            end
            if (expire && preempt_count_q != 16'hFFFF) begin
                preempt_count_q <= preempt_count_q + 16'd1;
            end
        end
    end

    assign switch_count  = switch_count_q;
    assign preempt_count = preempt_count_q;
`endif

    // switch_req decodes straight from the state register so reset drops it asynchronously
    assign switch_req  = (state_q == ST_DISPATCH);
    assign running     = (state_q == ST_RUN);
    assign idle        = (state_q == ST_IDLE);
    assign switch_pid  = sw_pid_q;
    assign switch_pc   = sw_pc_q;
    assign current_pid = cur_q;
    assign create_ok   = crt_ok_q;
    assign create_full = crt_full_q;
    assign create_pid  = crt_pid_q;

endmodule
